sll_shift_arbiter: RTL

Round-robin arbiter that shares one combinational 32-bit logical-left barrel shifter among `NREQ` requesters in the ALU. It accepts at most one shift operation per cycle over per-requester valid/ready handshakes. It registers the shifted result into a single tagged output stage with its own valid/ready handshake. Requester ports sit in front of the shifter; the output stage drives the ALU writeback mux.

---
 rtl/sll_shift_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/sll_shift_arbiter.sv
// Round-robin arbiter that shares one 32-bit logical-left barrel shifter among NREQ requesters.
// Results land in a single tagged output register with a valid/ready handshake.
module sll_shift_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [5*NREQ-1:0]    req_shamt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [IDW-1:0]       out_id
);

  logic [NREQ-1:0][31:0] a_arr;
  logic [NREQ-1:0][4:0]  sh_arr;
  logic [IDW-1:0]        ptr;
  logic [IDW-1:0]        gnt_idx;
  logic [NREQ-1:0]       gnt;
  logic                  gnt_any;
  logic                  can_accept;
  logic                  accept;
  logic [31:0]           a_sel;
  logic [4:0]            sh_sel;
  logic [31:0]           shifted;
  logic [IDW:0]          pos;

  assign a_arr      = req_a;
  assign sh_arr     = req_shamt;
  assign can_accept = !out_valid || out_ready;

  // Walk offsets ptr+1 .. ptr+NREQ; the first valid requester in that rotation wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = {1'b0, ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_any && pos == (IDW+1)'(i) && req_valid[i]) begin
          gnt_any = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = IDW'(i);
        end
      end
    end
  end

  // Reset gating keeps requesters from seeing a handshake while the stage is cleared.
  assign req_ready = (reset_n && can_accept) ? gnt : '0;
  assign accept    = |req_ready;

  // One-hot AND-OR mux avoids indexing past NREQ when 2^IDW > NREQ.
  always_comb begin
    a_sel  = '0;
    sh_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel  = a_sel | a_arr[i];
        sh_sel = sh_sel | sh_arr[i];
      end
    end
  end

  assign shifted = a_sel << sh_sel;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= IDW'(NREQ-1);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= shifted;
      out_id    <= gnt_idx;
      ptr       <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
